// File: rtl/fcims_pkg.sv
// Shared types and constants for the FCIMS billing controller.
package fcims_pkg;

    localparam int TOTAL_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BILL  = 2'd2
    } bill_state_t;

    localparam logic [1:0] ERR_QTY_ZERO = 2'd0;
    localparam logic [1:0] ERR_SHORT    = 2'd1;
    localparam logic [1:0] ERR_CT_OVF   = 2'd2;
    localparam logic [1:0] ERR_LIMIT    = 2'd3;

endpackage

// File: rtl/fcims_discount.sv
// Combinational bulk discount: totals at or above the threshold lose one eighth.
module fcims_discount #(
    parameter int TOTAL_W     = fcims_pkg::TOTAL_W_DEF,
    parameter int DISC_THRESH = 100
) (
    input  logic [TOTAL_W-1:0] total,
    output logic [TOTAL_W-1:0] amt
);

    localparam logic [TOTAL_W-1:0] THRESH = TOTAL_W'(DISC_THRESH);

    always_comb begin
        amt = total;
        if (total >= THRESH) amt = total - (total >> 3);
    end

endmodule

// File: rtl/fcims_bill_ctrl.sv
// Order billing controller: accumulates sale lines, tracks stock, issues a bill.
// Build option: FCIMS_DISCOUNT_EN enables the bulk discount on the bill amount.
//
// state | meaning
// IDLE  | no open order, items accepted
// ACCUM | order open, sales accumulating, checkout accepted
// BILL  | bill presented, waiting for bill_ready
module fcims_bill_ctrl
    import fcims_pkg::*;
#(
    parameter int TOTAL_W     = TOTAL_W_DEF,
    parameter int MAX_LINES   = 8,
    parameter int DISC_THRESH = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               item_valid,
    output logic               item_ready,
    input  logic               item_ctrl,
    input  logic [3:0]         item_qty,
    input  logic [7:0]         fprice,
    input  logic [3:0]         new_ct,
    output logic [3:0]         ct,
    input  logic               checkout,
    output logic               bill_valid,
    input  logic               bill_ready,
    output logic [TOTAL_W-1:0] bill_amt,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [3:0]         line_cnt
);

    bill_state_t        state;
    logic [TOTAL_W-1:0] total;

    logic               xfer;
    logic               rej;
    logic [1:0]         rej_code;
    logic               accept;
    logic               sale_ok;
    logic [TOTAL_W:0]   sum;
    logic [4:0]         ct_sum;
    logic [TOTAL_W-1:0] total_upd;
    logic [TOTAL_W-1:0] bill_next;

    assign item_ready = (state != BILL);

    always_comb begin
        xfer     = item_valid && item_ready;
        sum      = {1'b0, total} + (TOTAL_W + 1)'(fprice);
        ct_sum   = {1'b0, ct} + {1'b0, item_qty};
        rej      = 1'b0;
        rej_code = ERR_QTY_ZERO;
        if (xfer) begin
            if (item_qty == 4'd0) begin
                rej      = 1'b1;
                rej_code = ERR_QTY_ZERO;
            end else if (item_ctrl && (item_qty > ct)) begin
                rej      = 1'b1;
                rej_code = ERR_SHORT;
            end else if (!item_ctrl && (ct_sum > 5'd15)) begin
                rej      = 1'b1;
                rej_code = ERR_CT_OVF;
            end else if (item_ctrl && (sum[TOTAL_W] || (line_cnt == 4'(MAX_LINES)))) begin
                rej      = 1'b1;
                rej_code = ERR_LIMIT;
            end
        end
        accept    = xfer && !rej;
        sale_ok   = accept && item_ctrl;
        total_upd = sale_ok ? sum[TOTAL_W-1:0] : total;
    end

`ifdef FCIMS_DISCOUNT_EN
    fcims_discount #(
        .TOTAL_W     (TOTAL_W),
        .DISC_THRESH (DISC_THRESH)
    ) u_discount (
        .total (total_upd),
        .amt   (bill_next)
    );
`else
    assign bill_next = total_upd;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ct         <= 4'd0;
            total      <= '0;
            line_cnt   <= 4'd0;
            bill_valid <= 1'b0;
            bill_amt   <= '0;
            err        <= 1'b0;
            err_code   <= ERR_QTY_ZERO;
        end else begin
            err <= 1'b0;
            if (rej) begin
                err      <= 1'b1;
                err_code <= rej_code;
            end
            if (accept) ct <= new_ct;
            if (sale_ok) begin
                total    <= total_upd;
                line_cnt <= line_cnt + 4'd1;
            end
            case (state)
                IDLE: begin
                    if (sale_ok) state <= ACCUM;
                end
                ACCUM: begin
                    // Same-cycle sale is already folded into total_upd / bill_next.
                    if (checkout) begin
                        state      <= BILL;
                        bill_valid <= 1'b1;
                        bill_amt   <= bill_next;
                    end
                end
                BILL: begin
                    if (bill_ready) begin
                        state      <= IDLE;
                        total      <= '0;
                        line_cnt   <= 4'd0;
                        bill_valid <= 1'b0;
                        bill_amt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcims_bill_ctrl.sv
// Directed self-checking bench for fcims_bill_ctrl (default parameters).
module tb_fcims_bill_ctrl;
    import fcims_pkg::*;

    localparam int TW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          item_valid;
    logic          item_ready;
    logic          item_ctrl;
    logic [3:0]    item_qty;
    logic [7:0]    fprice;
    logic [3:0]    new_ct;
    logic [3:0]    ct;
    logic          checkout;
    logic          bill_valid;
    logic          bill_ready;
    logic [TW-1:0] bill_amt;
    logic          err;
    logic [1:0]    err_code;
    logic [3:0]    line_cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int m_ct      = 0;
    int exp_disc;

    fcims_bill_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .item_valid (item_valid),
        .item_ready (item_ready),
        .item_ctrl  (item_ctrl),
        .item_qty   (item_qty),
        .fprice     (fprice),
        .new_ct     (new_ct),
        .ct         (ct),
        .checkout   (checkout),
        .bill_valid (bill_valid),
        .bill_ready (bill_ready),
        .bill_amt   (bill_amt),
        .err        (err),
        .err_code   (err_code),
        .line_cnt   (line_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle item request; new_ct models the external adder/subtracter.
    task automatic item(input logic sale, input int qty, input int price, input logic co);
        int nc;
        nc         = sale ? (m_ct - qty) : (m_ct + qty);
        item_valid = 1'b1;
        item_ctrl  = sale;
        item_qty   = 4'(qty);
        fprice     = 8'(price);
        new_ct     = 4'(nc);
        checkout   = co;
        tick();
        item_valid = 1'b0;
        checkout   = 1'b0;
    endtask

    task automatic do_checkout();
        checkout = 1'b1;
        tick();
        checkout = 1'b0;
    endtask

    task automatic finish_bill();
        bill_ready = 1'b1;
        tick();
        bill_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; item_valid = 1'b0; item_ctrl = 1'b0; item_qty = 4'd0;
        fprice = 8'd0; new_ct = 4'd0; checkout = 1'b0; bill_ready = 1'b0;
        tick(); tick();
        check("rst_ct", int'(ct), 0);
        check("rst_bill_valid", int'(bill_valid), 0);
        check("rst_bill_amt", int'(bill_amt), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_line_cnt", int'(line_cnt), 0);
        check("rst_item_ready", int'(item_ready), 1);
        check("rst_state", int'(dut.state), int'(IDLE));
        rst_n = 1'b1;
        tick();

        // Restock 5 from empty
        item(1'b0, 5, 0, 1'b0); m_ct = 5;
        check("restock_ct", int'(ct), 5);
        check("restock_err", int'(err), 0);
        check("restock_state", int'(dut.state), int'(IDLE));
        check("restock_lines", int'(line_cnt), 0);

        // Sale of 6 with only 5 in stock
        item(1'b1, 6, 30, 1'b0);
        check("short_err", int'(err), 1);
        check("short_code", int'(err_code), 1);
        check("short_ct", int'(ct), 5);
        check("short_total", int'(dut.total), 0);
        tick();
        check("short_err_pulse", int'(err), 0);
        check("short_code_hold", int'(err_code), 1);

        // Two sales then checkout
        item(1'b1, 2, 14, 1'b0); m_ct = 3;
        check("sale1_ct", int'(ct), 3);
        check("sale1_state", int'(dut.state), int'(ACCUM));
        item(1'b1, 1, 7, 1'b0); m_ct = 2;
        check("sale2_lines", int'(line_cnt), 2);
        do_checkout();
        check("co_bill_valid", int'(bill_valid), 1);
        check("co_bill_amt", int'(bill_amt), 21);
        check("co_ct", int'(ct), 2);
        check("co_lines", int'(line_cnt), 2);

        // Bill held while bill_ready low; items refused
        for (int i = 0; i < 3; i++) begin
            item(1'b0, 1, 0, 1'b0);
            check("hold_amt", int'(bill_amt), 21);
            check("hold_valid", int'(bill_valid), 1);
            check("hold_item_ready", int'(item_ready), 0);
            check("hold_ct", int'(ct), 2);
        end
        finish_bill();
        check("done_valid", int'(bill_valid), 0);
        check("done_state", int'(dut.state), int'(IDLE));
        check("done_total", int'(dut.total), 0);
        check("done_lines", int'(line_cnt), 0);
        check("done_ct", int'(ct), 2);

        // Zero quantity and stock overflow
        item(1'b0, 0, 0, 1'b0);
        check("zero_err", int'(err), 1);
        check("zero_code", int'(err_code), 0);
        item(1'b0, 14, 0, 1'b0);
        check("ovf_code", int'(err_code), 2);
        check("ovf_ct", int'(ct), 2);

        // Checkout in IDLE is ignored
        do_checkout();
        check("idle_co_valid", int'(bill_valid), 0);
        check("idle_co_state", int'(dut.state), int'(IDLE));

        // Discount boundary cases
`ifdef FCIMS_DISCOUNT_EN
        exp_disc = 105;
`else
        exp_disc = 120;
`endif
        item(1'b1, 1, 120, 1'b0); m_ct = 1;
        do_checkout();
        check("disc_120", int'(bill_amt), exp_disc);
        finish_bill();
        item(1'b1, 1, 96, 1'b0); m_ct = 0;
        do_checkout();
        check("disc_96", int'(bill_amt), 96);
        finish_bill();

        // Line limit
        item(1'b0, 15, 0, 1'b0); m_ct = 15;
        for (int i = 0; i < 8; i++) begin
            item(1'b1, 1, 1, 1'b0); m_ct = m_ct - 1;
        end
        check("limit_lines", int'(line_cnt), 8);
        item(1'b1, 1, 1, 1'b0);
        check("limit_err", int'(err), 1);
        check("limit_code", int'(err_code), 3);
        check("limit_ct", int'(ct), 7);
        check("limit_total", int'(dut.total), 8);
        do_checkout();
        check("limit_bill", int'(bill_amt), 8);
        finish_bill();

        // Sale concurrent with checkout
        item(1'b1, 1, 10, 1'b0); m_ct = 6;
        item(1'b1, 1, 20, 1'b1); m_ct = 5;
        check("conc_valid", int'(bill_valid), 1);
        check("conc_amt", int'(bill_amt), 30);
        check("conc_lines", int'(line_cnt), 2);
        check("conc_ct", int'(ct), 5);

        // Reset during BILL
        rst_n = 1'b0;
        tick();
        check("rstbill_valid", int'(bill_valid), 0);
        check("rstbill_ct", int'(ct), 0);
        check("rstbill_state", int'(dut.state), int'(IDLE));
        check("rstbill_amt", int'(bill_amt), 0);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
